wca_read_unpacker: RTL and testbench

- Consumer stage directly downstream of the port read FIFO. Pulls 32-bit words from the FIFO read side (rd_en/rd_out/empty) and delivers IQ samples to the DSP datapath over a valid/ready handshake.
- Supports 16-bit IQ pass-through and 8-bit packed IQ (two samples per word).
- Keeps a 2-entry prefetch buffer so the output sustains one sample per clock.
- Reports underruns to the port status registers.

---
 rtl/wca_read_unpacker_if.sv | 28 ++
 rtl/wca_read_unpacker.sv | 143 ++++++++++++++
 tb/tb_wca_read_unpacker.sv | 282 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/wca_read_unpacker_if.sv
// FIFO read-side and IQ valid/ready signals between the read unpacker and its neighbours.
// master = unpacker side, slave = FIFO/sink side.
interface wca_read_unpacker_if;
    logic        fifo_empty;
    logic        fifo_rd_en;
    logic [31:0] fifo_dout;
    logic [31:0] iq_out;
    logic        iq_valid;
    logic        iq_ready;

    modport master (
        input  fifo_empty,
        input  fifo_dout,
        input  iq_ready,
        output fifo_rd_en,
        output iq_out,
        output iq_valid
    );

    modport slave (
        output fifo_empty,
        output fifo_dout,
        output iq_ready,
        input  fifo_rd_en,
        input  iq_out,
        input  iq_valid
    );
endinterface

// File: rtl/wca_read_unpacker.sv
// Pulls 32-bit words from a non-FWFT FIFO through a 2-word prefetch buffer and emits
// 16-bit or unpacked 8-bit IQ samples on a valid/ready handshake, counting starved cycles.
module wca_read_unpacker #(
    parameter int unsigned UNDERRUN_BITS = 16
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     enable,
    input  logic                     mode8,
    wca_read_unpacker_if.master      bus,
    output logic [UNDERRUN_BITS-1:0] underrun_count,
    output logic                     underrun
);

    logic [31:0]              head_q, head_d;
    logic [31:0]              tail_q, tail_d;
    logic [1:0]               cnt_q, cnt_d;
    logic                     inflight_q, inflight_d;
    logic                     half_q, half_d;
    logic                     started_q, started_d;
    logic                     mode_q, mode_d;
    logic                     enable_q, enable_d;
    logic [UNDERRUN_BITS-1:0] underrun_count_q, underrun_count_d;
    logic                     underrun_q, underrun_d;

    logic       valid;
    logic       accept;
    logic       pop;
    logic       push;
    logic       rd_en;
    logic [2:0] level;

    assign valid  = enable && (cnt_q != 2'd0);
    assign accept = valid && bus.iq_ready;
    assign pop    = accept && (!mode_q || half_q);
    assign push   = inflight_q && enable;

    // Projected occupancy including the word already on its way out of the FIFO.
    assign level = {1'b0, cnt_q} + {2'b00, inflight_q} - {2'b00, pop};
    assign rd_en = !reset && enable && !bus.fifo_empty && (level < 3'd2);

    assign bus.fifo_rd_en = rd_en;
    assign bus.iq_valid   = valid;
    assign underrun_count = underrun_count_q;
    assign underrun       = underrun_q;

    always_comb begin
        bus.iq_out = head_q;
        if (mode_q) begin
            if (!half_q) begin
                bus.iq_out = {head_q[7:0], 8'h00, head_q[15:8], 8'h00};
            end else begin
                bus.iq_out = {head_q[23:16], 8'h00, head_q[31:24], 8'h00};
            end
        end
    end

    always_comb begin
        head_d           = head_q;
        tail_d           = tail_q;
        cnt_d            = cnt_q + {1'b0, push} - {1'b0, pop};
        inflight_d       = rd_en;
        half_d           = half_q;
        started_d        = started_q;
        mode_d           = mode_q;
        enable_d         = enable;
        underrun_count_d = underrun_count_q;
        underrun_d       = underrun_q;

        unique case ({pop, push})
            2'b10: head_d = tail_q;
            2'b01: begin
                if (cnt_q == 2'd0) begin
                    head_d = bus.fifo_dout;
                end else begin
                    tail_d = bus.fifo_dout;
                end
            end
            2'b11: begin
                if (cnt_q == 2'd1) begin
                    head_d = bus.fifo_dout;
                end else begin
                    head_d = tail_q;
                    tail_d = bus.fifo_dout;
                end
            end
            default: ;
        endcase

        if (!enable) begin
            cnt_d     = 2'd0;
            half_d    = 1'b0;
            started_d = 1'b0;
            mode_d    = mode8;
        end else if (accept) begin
            started_d = 1'b1;
            if (mode_q) begin
                half_d = !half_q;
            end
        end

        // A fresh enable starts a new underrun accounting window.
        if (enable && !enable_q) begin
            underrun_count_d = '0;
            underrun_d       = 1'b0;
        end else if (enable && started_q && bus.iq_ready && !valid) begin
            underrun_d = 1'b1;
            if (underrun_count_q != {UNDERRUN_BITS{1'b1}}) begin
                underrun_count_d = underrun_count_q + UNDERRUN_BITS'(1);
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head_q           <= '0;
            tail_q           <= '0;
            cnt_q            <= 2'd0;
            inflight_q       <= 1'b0;
            half_q           <= 1'b0;
            started_q        <= 1'b0;
            mode_q           <= 1'b0;
            enable_q         <= 1'b0;
            underrun_count_q <= '0;
            underrun_q       <= 1'b0;
        end else begin
            head_q           <= head_d;
            tail_q           <= tail_d;
            cnt_q            <= cnt_d;
            inflight_q       <= inflight_d;
            half_q           <= half_d;
            started_q        <= started_d;
            mode_q           <= mode_d;
            enable_q         <= enable_d;
            underrun_count_q <= underrun_count_d;
            underrun_q       <= underrun_d;
        end
    end

    // The read throttle must never let a captured word land in a full buffer.
    assert property (@(posedge clock) disable iff (reset) !(push && !pop && (cnt_q == 2'd2)));

endmodule

// File: tb/tb_wca_read_unpacker.sv
// Directed + randomized bench for wca_read_unpacker: a queue-based FIFO model feeds the DUT and a
// sample-level scoreboard predicts the handshake, read strobes and underrun status every cycle.
module tb_wca_read_unpacker;

    logic        clock;
    logic        reset;
    logic        enable;
    logic        mode8;
    logic [15:0] underrun_count;
    logic        underrun;

    wca_read_unpacker_if bus ();

    wca_read_unpacker #(
        .UNDERRUN_BITS(16)
    ) dut (
        .clock         (clock),
        .reset         (reset),
        .enable        (enable),
        .mode8         (mode8),
        .bus           (bus),
        .underrun_count(underrun_count),
        .underrun      (underrun)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    int          checks = 0;
    int          errors = 0;
    int          n_acc  = 0;
    logic [31:0] acc_log[$];
    logic [31:0] fifo_q[$];
    logic [31:0] exp_q[$];
    bit          infl_v    = 1'b0;
    logic [31:0] infl_w    = '0;
    bit          m_mode    = 1'b0;
    bit          m_started = 1'b0;
    bit          m_prev_e  = 1'b0;
    bit          m_flag    = 1'b0;
    int unsigned m_cnt     = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b", tag, obs, exp);
        end
    endtask

    // A word becomes one sample (16-bit IQ) or two byte-pair samples, low pair first.
    function automatic void push_samples(input logic [31:0] w);
        if (!m_mode) begin
            exp_q.push_back(w);
        end else begin
            exp_q.push_back({w[7:0], 8'h00, w[15:8], 8'h00});
            exp_q.push_back({w[23:16], 8'h00, w[31:24], 8'h00});
        end
    endfunction

    task automatic load(input logic [31:0] w);
        fifo_q.push_back(w);
        bus.fifo_empty = 1'b0;
    endtask

    // One clock: check outputs mid-cycle, advance the models, update FIFO outputs after the edge.
    task automatic cycle();
        bit          ev, acc, pword, erd, rd;
        int          words, lvl;
        logic [31:0] w, s;
        w = '0;
        @(negedge clock);
        words = m_mode ? (exp_q.size() + 1) / 2 : exp_q.size();
        ev    = enable && (exp_q.size() != 0);
        acc   = ev && bus.iq_ready;
        pword = acc && (!m_mode || (exp_q.size() % 2 == 1));
        lvl   = words + int'(infl_v) - int'(pword);
        erd   = !reset && enable && (fifo_q.size() != 0) && (lvl < 2);
        check1("iq_valid", bus.iq_valid, ev);
        check1("fifo_rd_en", bus.fifo_rd_en, erd);
        check("underrun_count", {16'h0, underrun_count}, m_cnt);
        check1("underrun", underrun, m_flag);
        if (acc) begin
            s = exp_q.pop_front();
            check("iq_out", bus.iq_out, s);
        end
        if (bus.iq_valid && bus.iq_ready) begin
            acc_log.push_back(bus.iq_out);
            n_acc++;
        end
        rd = bus.fifo_rd_en && (fifo_q.size() != 0);
        if (rd) w = fifo_q.pop_front();
        if (reset) begin
            exp_q.delete();
            infl_v    = 1'b0;
            m_started = 1'b0;
            m_prev_e  = 1'b0;
            m_flag    = 1'b0;
            m_cnt     = 0;
            m_mode    = 1'b0;
        end else begin
            if (enable && !m_prev_e) begin
                m_cnt  = 0;
                m_flag = 1'b0;
            end else if (enable && m_started && bus.iq_ready && !ev) begin
                m_flag = 1'b1;
                if (m_cnt < 65535) m_cnt++;
            end
            if (!enable) begin
                m_started = 1'b0;
                exp_q.delete();
                m_mode = mode8;
            end else begin
                if (acc) m_started = 1'b1;
                if (infl_v) push_samples(infl_w);
            end
            m_prev_e = enable;
            infl_v   = rd;
            infl_w   = w;
        end
        @(posedge clock);
        #1;
        if (rd) bus.fifo_dout = w;
        bus.fifo_empty = (fifo_q.size() == 0);
    endtask

    initial begin
        int          n0;
        int          fed;
        int          budget;
        logic [31:0] rw[6];

        reset          = 1'b1;
        enable         = 1'b0;
        mode8          = 1'b0;
        bus.iq_ready   = 1'b0;
        bus.fifo_empty = 1'b1;
        bus.fifo_dout  = '0;
        repeat (2) @(posedge clock);
        #1;
        check1("rst_iq_valid", bus.iq_valid, 1'b0);
        check1("rst_fifo_rd_en", bus.fifo_rd_en, 1'b0);
        check("rst_iq_out", bus.iq_out, 32'h0);
        check("rst_underrun_count", {16'h0, underrun_count}, 32'h0);
        check1("rst_underrun", underrun, 1'b0);
        reset = 1'b0;
        cycle();

        // 16-bit pass-through, FIFO preloaded, sink always ready.
        for (int i = 0; i < 8; i++) load(32'h00010002 + i * 32'h00010001);
        enable       = 1'b1;
        bus.iq_ready = 1'b1;
        n0           = n_acc;
        repeat (10) cycle();
        check("m16_count", n_acc - n0, 8);
        for (int i = 0; i < 8; i++) begin
            if (acc_log.size() > n0 + i) check("m16_data", acc_log[n0+i], 32'h00010002 + i * 32'h00010001);
        end
        check("m16_underrun_count", {16'h0, underrun_count}, 32'h0);

        // Packed 8-bit IQ: two words back to back.
        enable = 1'b0;
        mode8  = 1'b1;
        cycle();
        load(32'h44332211);
        load(32'h88776655);
        enable = 1'b1;
        n0     = n_acc;
        repeat (6) cycle();
        check("m8_count", n_acc - n0, 4);
        if (acc_log.size() >= n0 + 4) begin
            check("m8_s0", acc_log[n0],   32'h11002200);
            check("m8_s1", acc_log[n0+1], 32'h33004400);
            check("m8_s2", acc_log[n0+2], 32'h55006600);
            check("m8_s3", acc_log[n0+3], 32'h77008800);
        end

        // Random backpressure, 64 preloaded words in 16-bit mode.
        enable = 1'b0;
        mode8  = 1'b0;
        cycle();
        for (int i = 0; i < 64; i++) load($urandom);
        enable = 1'b1;
        n0     = n_acc;
        budget = 0;
        while ((n_acc - n0 < 64) && (budget < 2000)) begin
            bus.iq_ready = 1'($urandom_range(0, 1));
            cycle();
            budget++;
        end
        check("bp16_delivered", n_acc - n0, 64);

        // Random backpressure and a bursty FIFO in 8-bit mode.
        enable = 1'b0;
        mode8  = 1'b1;
        cycle();
        enable = 1'b1;
        n0     = n_acc;
        fed    = 0;
        budget = 0;
        while ((n_acc - n0 < 48) && (budget < 3000)) begin
            if ((fed < 24) && ($urandom_range(0, 2) != 0)) begin
                load($urandom);
                fed++;
            end
            bus.iq_ready = 1'($urandom_range(0, 1));
            cycle();
            budget++;
        end
        check("bp8_delivered", n_acc - n0, 48);

        // Underrun: four words, then five starved cycles.
        enable = 1'b0;
        mode8  = 1'b0;
        cycle();
        for (int i = 0; i < 4; i++) load(32'hA0000000 + i);
        enable       = 1'b1;
        bus.iq_ready = 1'b1;
        repeat (11) cycle();
        check("ur_count", {16'h0, underrun_count}, 32'd5);
        check1("ur_flag", underrun, 1'b1);

        // Drop enable while the first word is in flight.
        load(32'hCAFE0001);
        load(32'hCAFE0002);
        load(32'hCAFE0003);
        load(32'hCAFE0004);
        cycle();
        enable = 1'b0;
        cycle();
        enable = 1'b1;
        cycle();
        #1;
        check("drop_ur_cleared", {16'h0, underrun_count}, 32'h0);
        n0 = n_acc;
        repeat (3) cycle();
        check("drop_count", n_acc - n0, 2);
        if (acc_log.size() > n0) check("drop_next_word", acc_log[n0], 32'hCAFE0002);
        repeat (3) cycle();

        // Reset mid-stream with a full buffer.
        for (int i = 0; i < 6; i++) begin
            rw[i] = $urandom;
            load(rw[i]);
        end
        bus.iq_ready = 1'b0;
        repeat (4) cycle();
        reset = 1'b1;
        cycle();
        #1;
        check1("mid_rst_iq_valid", bus.iq_valid, 1'b0);
        check("mid_rst_iq_out", bus.iq_out, 32'h0);
        check1("mid_rst_fifo_rd_en", bus.fifo_rd_en, 1'b0);
        check("mid_rst_underrun_count", {16'h0, underrun_count}, 32'h0);
        cycle();
        reset        = 1'b0;
        bus.iq_ready = 1'b1;
        n0           = n_acc;
        repeat (8) cycle();
        check("post_rst_count", n_acc - n0, 4);
        for (int i = 0; i < 4; i++) begin
            if (acc_log.size() > n0 + i) check("post_rst_data", acc_log[n0+i], rw[2+i]);
        end

        // Long starvation saturates the counter.
        repeat (65540) cycle();
        check("sat_count", {16'h0, underrun_count}, 32'h0000FFFF);
        check1("sat_flag", underrun, 1'b1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
